// File: rtl/matmul_pkg.sv
// Shared types and default sizing for the matrix-multiply loader and engine.
package matmul_pkg;
  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_ADDR_WIDTH  = 12;
  localparam int DEFAULT_VECTOR_SIZE = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    LOAD_Y = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4
  } loader_state_t;
endpackage

// File: rtl/matmul_loader_if.sv
// FWFT FIFO input, X/Y BRAM write ports and engine start/done handshake.
interface matmul_loader_if #(
  parameter int DATA_WIDTH = matmul_pkg::DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = matmul_pkg::DEFAULT_ADDR_WIDTH
);
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;
  logic [DATA_WIDTH-1:0] x_din;
  logic [ADDR_WIDTH-1:0] x_addr;
  logic                  x_wr_en;
  logic [DATA_WIDTH-1:0] y_din;
  logic [ADDR_WIDTH-1:0] y_addr;
  logic                  y_wr_en;
  logic                  mm_start;
  logic                  mm_done;
  logic                  busy;

  modport master (
    input  in_dout, in_empty, mm_done,
    output in_rd_en, x_din, x_addr, x_wr_en, y_din, y_addr, y_wr_en, mm_start, busy
  );

  modport slave (
    output in_dout, in_empty, mm_done,
    input  in_rd_en, x_din, x_addr, x_wr_en, y_din, y_addr, y_wr_en, mm_start, busy
  );
endinterface

// File: rtl/matmul_loader.sv
// Streams one X then one Y matrix row-major from a FWFT FIFO into BRAMs, 1 word/cycle,
// then pulses start and holds off the next frame until the engine reports done.
module matmul_loader
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int VECTOR_SIZE = DEFAULT_VECTOR_SIZE
) (
  input logic             clock,
  input logic             reset,
  matmul_loader_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VECTOR_SIZE * VECTOR_SIZE - 1);

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  in_x, in_y, pop;

  assign in_x = (state_q == LOAD_X);
  assign in_y = (state_q == LOAD_Y);
  assign pop  = (in_x || in_y) && !bus.in_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!bus.in_empty) begin
          state_d = LOAD_X;
          cnt_d   = '0;
        end
      end
      LOAD_X, LOAD_Y: begin
        // A stalled FIFO freezes the address so no BRAM location is ever skipped.
        if (pop) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = in_x ? LOAD_Y : START;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      START:   state_d = WAIT;
      WAIT:    if (bus.mm_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_rd_en = pop;
  assign bus.x_wr_en  = in_x && !bus.in_empty;
  assign bus.x_din    = in_x ? bus.in_dout : '0;
  assign bus.x_addr   = in_x ? cnt_q : '0;
  assign bus.y_wr_en  = in_y && !bus.in_empty;
  assign bus.y_din    = in_y ? bus.in_dout : '0;
  assign bus.y_addr   = in_y ? cnt_q : '0;
  assign bus.mm_start = (state_q == START);
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_matmul_loader.sv
// Directed bench: small 4x4 loader for framing/handshake cases, default-size loader for a full frame.
module tb_matmul_loader;
  import matmul_pkg::*;

  localparam int DW   = 32;
  localparam int AW_A = 4;
  localparam int VS_A = 4;

  typedef struct packed {
    logic        is_y;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  matmul_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_A)) bus_a ();
  matmul_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(12))   bus_b ();

  matmul_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_A), .VECTOR_SIZE(VS_A)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a.master)
  );
  matmul_loader dut_b (
    .clock(clock), .reset(reset), .bus(bus_b.master)
  );

  logic [31:0] fifo_a[$];
  logic [31:0] fifo_b[$];
  wr_t         sb_a[$];
  wr_t         sb_b[$];
  logic        gate_a = 1'b0, toggle_a = 1'b0, pend_a, pend_b;
  int          checks = 0, errors = 0, pops_a = 0;
  bit          contig_a = 1'b1;
  int          last_wr_a = -1, last_y15_a = -1, prev_start_a = 0;
  int          last_x_b = -1, first_y_b = -1, last_y_b = -1;
  wr_t         e_a, e_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void drive();
    bus_a.in_empty = gate_a || (fifo_a.size() == 0);
    bus_a.in_dout  = (fifo_a.size() != 0) ? fifo_a[0] : '0;
    bus_b.in_empty = (fifo_b.size() == 0);
    bus_b.in_dout  = (fifo_b.size() != 0) ? fifo_b[0] : '0;
  endfunction

  function automatic void push_a(input int pos, input logic [31:0] v);
    fifo_a.push_back(v);
    sb_a.push_back('{is_y: (pos >= 16), addr: 12'(pos % 16), data: v});
    drive();
  endfunction

  task automatic tick_neg();
    @(negedge clock);
    pend_a = bus_a.in_rd_en;
    pend_b = bus_b.in_rd_en;
  endtask

  task automatic tick_pos();
    @(posedge clock);
    #1;
    if (pend_a) begin void'(fifo_a.pop_front()); pops_a++; end
    if (pend_b) void'(fifo_b.pop_front());
    if (toggle_a) gate_a = ~gate_a;
    drive();
  endtask

  // Returns at the negedge of the start cycle when found.
  task automatic wait_start_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick_neg();
      if (bus_a.mm_start) begin ok = 1'b1; break; end
      tick_pos();
    end
  endtask

  task automatic wait_idle_a(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick_neg();
      if (!bus_a.busy) begin ok = 1'b1; break; end
      tick_pos();
    end
    chk("wait_idle_timeout", ok, 1'b1);
    tick_pos();
  endtask

  // Engine model for the small loader: done falls after start, rises 50 cycles later.
  initial begin
    bus_a.mm_done = 1'b1;
    bus_b.mm_done = 1'b0;
    forever begin
      @(negedge clock);
      if (bus_a.mm_start) begin
        @(posedge clock);
        #1 bus_a.mm_done = 1'b0;
        repeat (50) @(posedge clock);
        #1 bus_a.mm_done = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (bus_a.x_wr_en || bus_a.y_wr_en) begin
        if (sb_a.size() == 0) chk("a_unexpected_write", 1'b1, 1'b0);
        else begin
          e_a = sb_a.pop_front();
          chk("a_wr_sel", bus_a.y_wr_en, e_a.is_y);
          chk("a_wr_addr", bus_a.y_wr_en ? bus_a.y_addr : bus_a.x_addr, e_a.addr);
          chk("a_wr_data", bus_a.y_wr_en ? bus_a.y_din : bus_a.x_din, e_a.data);
        end
        chk("a_wr_nonempty", bus_a.in_empty, 1'b0);
        if (contig_a && last_wr_a >= 0) chk("a_no_gap", cyc, last_wr_a + 1);
        last_wr_a = cyc;
        if (bus_a.y_wr_en && bus_a.y_addr == 4'd15) last_y15_a = cyc;
      end
      if (bus_a.busy)
        chk("a_exclusive", (bus_a.x_wr_en & bus_a.y_wr_en) |
                           (bus_a.mm_start & (bus_a.x_wr_en | bus_a.y_wr_en)), 1'b0);
      if (bus_a.mm_start) begin
        chk("a_start_width", prev_start_a, 0);
        last_wr_a = -1;
      end
      prev_start_a = bus_a.mm_start ? 1 : 0;
    end
  end

  always @(negedge clock) begin
    if (!reset && (bus_b.x_wr_en || bus_b.y_wr_en)) begin
      if (sb_b.size() == 0) chk("b_unexpected_write", 1'b1, 1'b0);
      else begin
        e_b = sb_b.pop_front();
        chk("b_wr_sel", bus_b.y_wr_en, e_b.is_y);
        chk("b_wr_addr", bus_b.y_wr_en ? bus_b.y_addr : bus_b.x_addr, e_b.addr);
        chk("b_wr_data", bus_b.y_wr_en ? bus_b.y_din : bus_b.x_din, e_b.data);
      end
      if (bus_b.x_wr_en && bus_b.x_addr == 12'd4095) last_x_b = cyc;
      if (bus_b.y_wr_en && bus_b.y_addr == 12'd0) first_y_b = cyc;
      if (bus_b.y_wr_en && bus_b.y_addr == 12'd4095) last_y_b = cyc;
    end
  end

  initial begin
    bit ok;
    int wait_cnt;
    drive();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state of both loaders.
    tick_neg();
    chk("rst_a_outputs", {bus_a.in_rd_en, bus_a.x_wr_en, bus_a.x_addr, bus_a.x_din,
                          bus_a.y_wr_en, bus_a.y_addr, bus_a.y_din, bus_a.mm_start}, '0);
    chk("rst_a_busy", bus_a.busy, 1'b0);
    chk("rst_b_outputs", {bus_b.in_rd_en, bus_b.x_wr_en, bus_b.x_addr,
                          bus_b.y_wr_en, bus_b.y_addr, bus_b.mm_start}, '0);
    chk("rst_b_busy", bus_b.busy, 1'b0);
    tick_pos();

    // Two back-to-back frames queued: 0..31 then 32..63.
    for (int i = 0; i < 64; i++) push_a(i % 32, 32'(i));
    wait_start_a(300, ok);
    chk("f1_start_seen", ok, 1'b1);
    chk("f1_start_after_y15", cyc, last_y15_a + 1);
    chk("f1_sb_remaining", sb_a.size(), 32);
    tick_pos();

    wait_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick_neg();
      if (bus_a.mm_done) break;
      chk("wait_busy", bus_a.busy, 1'b1);
      chk("wait_no_read", bus_a.in_rd_en, 1'b0);
      wait_cnt++;
      tick_pos();
    end
    chk("wait_cycles", wait_cnt, 50);
    chk("wait_busy_at_done", bus_a.busy, 1'b1);
    tick_pos();
    tick_neg();
    chk("idle_after_done_busy", bus_a.busy, 1'b0);
    chk("idle_after_done_rd", bus_a.in_rd_en, 1'b0);
    chk("wait_fifo_untouched", fifo_a.size(), 32);
    tick_pos();

    wait_start_a(300, ok);
    chk("f2_start_seen", ok, 1'b1);
    chk("f2_sb_empty", sb_a.size(), 0);
    chk("f2_fifo_empty", fifo_a.size(), 0);
    tick_pos();
    wait_idle_a(100);

    // FIFO empty every other cycle.
    contig_a = 1'b0;
    toggle_a = 1'b1;
    pops_a   = 0;
    for (int i = 0; i < 32; i++) push_a(i, 32'(100 + i));
    wait_start_a(300, ok);
    chk("gap_start_seen", ok, 1'b1);
    chk("gap_pops", pops_a, 32);
    chk("gap_sb_empty", sb_a.size(), 0);
    toggle_a = 1'b0;
    gate_a   = 1'b0;
    tick_pos();
    wait_idle_a(100);

    // Reset in LOAD_Y at cnt 7, then resume with the remaining FIFO words as a new frame.
    for (int i = 0; i < 32; i++) push_a(i, 32'(200 + i));
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick_neg();
      if (bus_a.y_wr_en && bus_a.y_addr == 4'd7) begin ok = 1'b1; break; end
      tick_pos();
    end
    chk("rst_mid_found", ok, 1'b1);
    reset = 1'b1;
    tick_pos();
    reset = 1'b0;
    sb_a.delete();
    for (int k = 0; k < fifo_a.size(); k++)
      sb_a.push_back('{is_y: 1'b0, addr: 12'(k), data: fifo_a[k]});
    tick_neg();
    chk("rst_mid_outputs", {bus_a.in_rd_en, bus_a.x_wr_en, bus_a.x_addr, bus_a.x_din,
                            bus_a.y_wr_en, bus_a.y_addr, bus_a.y_din, bus_a.mm_start}, '0);
    chk("rst_mid_busy", bus_a.busy, 1'b0);
    chk("rst_mid_fifo_left", fifo_a.size(), 8);
    for (int i = 8; i < 32; i++) push_a(i, 32'(224 + i));
    tick_pos();
    wait_start_a(300, ok);
    chk("rst_resume_start", ok, 1'b1);
    chk("rst_resume_sb_empty", sb_a.size(), 0);
    tick_pos();
    wait_idle_a(100);

    // Full default-size frame on the second loader.
    for (int i = 0; i < 8192; i++) begin
      fifo_b.push_back(32'(i));
      sb_b.push_back('{is_y: (i >= 4096), addr: 12'(i % 4096), data: 32'(i)});
    end
    drive();
    ok = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      tick_neg();
      if (bus_b.mm_start) begin ok = 1'b1; break; end
      tick_pos();
    end
    chk("big_start_seen", ok, 1'b1);
    chk("big_sb_empty", sb_b.size(), 0);
    chk("big_x_to_y_no_gap", first_y_b, last_x_b + 1);
    chk("big_start_after_last_y", cyc, last_y_b + 1);
    tick_pos();
    tick_neg();
    chk("big_start_one_cycle", bus_b.mm_start, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matmul_loader.md
Name: matmul_loader

Overview:
Upstream feeder for the matrix-multiply engine. Drains a first-word-fall-through input FIFO and writes one full VECTOR_SIZE x VECTOR_SIZE X matrix, then one Y matrix, row-major into the X and Y BRAMs. It then pulses start to the engine and holds off further loading until the engine reports done. One frame is 2*VECTOR_SIZE^2 words: X first, then Y.

Parameters:
DATA_WIDTH, 32, width of matrix elements and FIFO/BRAM data
ADDR_WIDTH, 12, BRAM address width; VECTOR_SIZE^2 must be <= 2^ADDR_WIDTH
VECTOR_SIZE, 64, matrix dimension N (N x N)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_dout  input  DATA_WIDTH  FIFO head word (FWFT, valid whenever in_empty=0)
in_empty  input  1  FIFO empty flag
in_rd_en  output  1  FIFO pop; head word consumed at this edge
x_din  output  DATA_WIDTH  X BRAM write data
x_addr  output  ADDR_WIDTH  X BRAM write address
x_wr_en  output  1  X BRAM write enable
y_din  output  DATA_WIDTH  Y BRAM write data
y_addr  output  ADDR_WIDTH  Y BRAM write address
y_wr_en  output  1  Y BRAM write enable
mm_start  output  1  one-cycle start pulse to the engine
mm_done  input  1  engine done (level; cleared by engine the cycle after start)
busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Registers: state, cnt (ADDR_WIDTH bits). All outputs are combinational decode of state, cnt, in_empty and in_dout.
- Reset: state=IDLE, cnt=0.
  - In the cycle after reset is sampled, all outputs are 0.
  - Reset has priority over every transition. It may arrive in any state. BRAM contents after a partial load are don't-care.
- Constant LAST = VECTOR_SIZE*VECTOR_SIZE-1, sized to ADDR_WIDTH.
- IDLE:
  - No reads.
  - If in_empty=0, go to LOAD_X with cnt=0. Leaving IDLE costs one cycle; the first word is popped in LOAD_X.
- LOAD_X:
  - in_rd_en = !in_empty.
  - x_wr_en = in_rd_en, x_din = in_dout, x_addr = cnt.
  - On a pop: cnt += 1. If cnt==LAST, set cnt=0 and go to LOAD_Y.
  - Without a pop, nothing changes; addresses never skip.
- LOAD_Y: identical to LOAD_X but drives the y_* outputs. The pop at cnt==LAST goes to START with cnt=0.
- The LOAD_X -> LOAD_Y transition has no bubble. If the FIFO stays non-empty, y_addr 0 is written the cycle after x_addr LAST.
- START: mm_start=1 for exactly this one cycle, no reads, then go to WAIT. mm_done is not sampled in START.
- WAIT:
  - No reads; FIFO data for the next frame stays queued.
  - If mm_done=1, go to IDLE.
  - The engine clears done the cycle after seeing start, so the first WAIT cycle sees 0. A stale done is never accepted.
- X and Y write enables are never high together. mm_start is never high with either write enable.
- Throughput: 1 word/cycle while the FIFO is non-empty.
- Minimum frame latency: 1 (IDLE) + 2*(LAST+1) + 1 (START) cycles to the mm_start pulse.

Decomposition:
- Shared package matmul_pkg holds:
  - loader_state_t enum {IDLE, LOAD_X, LOAD_Y, START, WAIT}, 3-bit;
  - parameter defaults DATA_WIDTH, ADDR_WIDTH, VECTOR_SIZE, so loader and engine agree.
- No sub-module; the FSM plus one counter is a single module.

Test Plan:
1. VECTOR_SIZE=4, FIFO preloaded with words 0..31 -> x writes at addr 0..15 with data 0..15 on consecutive cycles. Then y writes at addr 0..15 with data 16..31 and no gap cycle. mm_start is high for exactly 1 cycle, the cycle after the y_addr 15 write.
2. VECTOR_SIZE=4, in_empty toggles every other cycle -> writes only on non-empty cycles, addresses strictly 0,1,2,... with no skips or repeats, 32 total pops.
3. Engine model: done=1 initially, cleared the cycle after mm_start, raised 50 cycles later -> busy stays 1 through WAIT and is 0 the cycle after done is sampled 1. No in_rd_en during WAIT even with 32 words queued.
4. Reset asserted in LOAD_Y at cnt=7 -> next cycle all outputs 0 and busy=0. The next frame writes x_addr 0 first with the FIFO head word.
5. Back-to-back frames queued (64 words, VECTOR_SIZE=4) -> second LOAD_X starts only after WAIT->IDLE. The second frame's first x write uses data 32 at addr 0.
6. Default parameters, 8192 sequential words -> x_addr reaches 4095 with data 4095, the next cycle y_addr 0 with data 4096, the final y_addr 4095 with data 8191, then one mm_start pulse.
